// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encoding shared by the universal shift register and its bench
package shift_reg_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_RSVD = 3'b111
  } shift_mode_e;
endpackage

// File: rtl/shift_reg_univ_cnt.sv
// shift_reg_univ_cnt: saturating shift counter with a single done pulse on reaching WIDTH
module shift_reg_univ_cnt #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic sat;
  assign sat = cnt == CNT_W'(WIDTH);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      cnt  <= clear ? '0 : (step && !sat) ? cnt + CNT_W'(1) : cnt;
      done <= step && cnt == CNT_W'(WIDTH - 1);
    end
  end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift/rotate/load register with serial taps and shift counter
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  shift_mode_e      m;
  logic [WIDTH-1:0] q_nxt;
  logic             step, clear;
  assign m        = shift_mode_e'(mode);
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign step     = en && (m == MODE_SHL || m == MODE_SHR || m == MODE_ROL || m == MODE_ROR);
  assign clear    = en && (m == MODE_LOAD || m == MODE_CLR);
  always_comb begin
    q_nxt = !en             ? q :
            m == MODE_SHL   ? {q[WIDTH-2:0], sin_r} :
            m == MODE_SHR   ? {sin_l, q[WIDTH-1:1]} :
            m == MODE_ROL   ? {q[WIDTH-2:0], q[WIDTH-1]} :
            m == MODE_ROR   ? {q[0], q[WIDTH-1:1]} :
            m == MODE_LOAD  ? pdata :
            m == MODE_CLR   ? '0 : q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end
  shift_reg_univ_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .clear(clear),
    .cnt  (cnt),
    .done (done)
  );
endmodule
